// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues 1-cycle imem reads, buffers words in a prefetch queue.
// Optional FETCH_STATS_EN adds perf_fetched / perf_flushed counters.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALTED
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_pc;
    logic [XLEN-1:0] r_q_pc   [QDEPTH];
    logic [XLEN-1:0] r_q_inst [QDEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_run;
    logic            w_flush;
    logic [CW:0]     w_occ;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redir_pc;

    assign w_run      = (r_state == S_RUN);
    assign w_flush    = w_run && (redirect_valid || halt);
    // queued entries plus the response already on its way back
    assign w_occ      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue    = w_run && !redirect_valid && !halt
                        && (w_occ < (CW+1)'(QDEPTH));
    assign w_push     = r_inflight && !w_flush;
    assign w_pop      = if_valid && if_ready && !w_flush;
    assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign if_valid  = (r_count != '0);
    assign if_pc     = r_q_pc[r_rptr];
    assign if_inst   = r_q_inst[r_rptr];
    assign halted    = (r_state == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_inst[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                    if (redirect_valid) r_pc <= w_redir_pc;
                end
                S_RUN: begin
                    if (halt) r_state <= S_HALTED;
                    else if (redirect_valid) r_pc <= w_redir_pc;
                    else if (w_issue) r_pc <= r_pc + XLEN'(4);
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_BOOT;
            endcase

            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_pc;

            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_q_pc[r_wptr]   <= r_inflight_pc;
                    r_q_inst[r_wptr] <= imem_rdata;
                    r_wptr           <= r_wptr + PW'(1);
                end
                if (w_pop) r_rptr <= r_rptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetched;
    logic [31:0] r_flushed;
    logic [32:0] w_flush_sum;

    assign w_flush_sum  = {1'b0, r_flushed} + 33'(w_occ);
    assign perf_fetched = r_fetched;
    assign perf_flushed = r_flushed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetched <= '0;
            r_flushed <= '0;
        end else begin
            if (w_pop && (r_fetched != '1)) r_fetched <= r_fetched + 32'd1;
            if (w_flush) r_flushed <= w_flush_sum[32] ? '1 : w_flush_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random stimulus against a queue-based transaction model of fetch.
// Memory returns addr ^ KEY one cycle after each request.
module tb_fetch_unit;

    localparam int          QDEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] KEY    = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    fetch_unit #(
        .XLEN(32),
        .RESET_PC(RST_PC),
        .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_pc(if_pc),
        .if_inst(if_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .halted(halted)
`ifdef FETCH_STATS_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ KEY;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // model: 0=boot 1=run 2=halted
    int          m_state;
    logic [31:0] m_pc;
    bit          m_inf;
    logic [31:0] m_inf_pc;
    logic [63:0] m_q[$];
    longint      m_fetched;
    longint      m_flushed;

    function automatic longint sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    task automatic model_reset();
        m_state   = 0;
        m_pc      = RST_PC;
        m_inf     = 0;
        m_inf_pc  = '0;
        m_q.delete();
        m_fetched = 0;
        m_flushed = 0;
    endtask

    task automatic step(input bit i_rst, input bit i_rdy, input bit i_rv,
                        input logic [31:0] i_rpc, input bit i_halt);
        bit exp_req;
        bit exp_valid;
        @(negedge clk);
        rst            = i_rst;
        if_ready       = i_rdy;
        redirect_valid = i_rv;
        redirect_pc    = i_rpc;
        halt           = i_halt;
        #1;
        exp_req   = (m_state == 1) && (m_q.size() + int'(m_inf) < QDEPTH)
                    && !i_rv && !i_halt;
        exp_valid = (m_q.size() != 0);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", imem_addr, m_pc);
        check("if_valid", 32'(if_valid), 32'(exp_valid));
        check("halted", 32'(halted), 32'(m_state == 2));
        if (exp_valid) begin
            check("if_pc", if_pc, m_q[0][63:32]);
            check("if_inst", if_inst, m_q[0][31:0]);
        end
`ifdef FETCH_STATS_EN
        check("perf_fetched", perf_fetched, 32'(m_fetched));
        check("perf_flushed", perf_flushed, 32'(m_flushed));
`endif
        if (i_rst) begin
            model_reset();
        end else if (m_state == 0) begin
            m_state = 1;
            if (i_rv) m_pc = i_rpc & ~32'h3;
        end else if (m_state == 1) begin
            if (i_rv || i_halt) begin
                m_flushed = sat32(m_flushed + m_q.size() + int'(m_inf));
                m_q.delete();
                m_inf = 0;
                if (i_halt) m_state = 2;
                else m_pc = i_rpc & ~32'h3;
            end else begin
                if (exp_valid && i_rdy) begin
                    void'(m_q.pop_front());
                    m_fetched = sat32(m_fetched + 1);
                end
                if (m_inf) m_q.push_back({m_inf_pc, m_inf_pc ^ KEY});
                m_inf = exp_req;
                if (exp_req) begin
                    m_inf_pc = m_pc;
                    m_pc     = m_pc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] rpc;
        bit          r_rst;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);

        // streaming with decode always ready
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
        // stall decode until the queue fills
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h100, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
        // partially filled queue plus in-flight response
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h103, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 32'hFFFF_FFF8, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            r_rst = (m_state == 2) ? ($urandom_range(0, 9) == 0)
                                   : ($urandom_range(0, 199) == 0);
            step(r_rst, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 rpc, $urandom_range(0, 149) == 0);
        end

        // halt wins over a simultaneous redirect, then a mid-stream reset
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 32'h200, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 32'h300, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
